phase_tick_timer: RTL and testbench

- Consumer end of the slow-clock interface. Takes the divided clock (slowClk) back into the inClk domain.
- Turns each slowClk rising edge into a one-cycle tick enable.
- Uses the ticks to run a loadable countdown that times one traffic-light phase.
- The phase sequencer issues load/duration and waits for the done pulse before it advances to the next light state.

---
 rtl/phase_tick_timer.sv | 63 ++++++
 tb/tb_phase_tick_timer.sv | 89 ++++++++
 2 files changed

// File: rtl/phase_tick_timer.sv
// phase_tick_timer: turns slowClk rising edges into inClk tick enables and times a loadable, pausable traffic-light phase
module phase_tick_timer #(
  parameter int DW = 8,
  parameter int TICKS_PER_UNIT = 10
) (
  input  logic          inClk,
  input  logic          reset,
  input  logic          slowClk,
  input  logic          load,
  input  logic [DW-1:0] duration,
  input  logic          pause,
  output logic          tick,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] remaining
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSED} state_t;
  localparam logic [7:0] PRE_MAX = 8'(TICKS_PER_UNIT - 1);
  state_t state, state_n;
  logic s1, s2, s3, done_n;
  logic [7:0] pre, pre_n;
  logic [DW-1:0] rem_n;
  // sync flops reset high so an idle-high slowClk gives no false edge
  always_ff @(posedge inClk)
    if (reset) begin
      {s1, s2, s3} <= 3'b111;
      state <= IDLE;
      pre <= '0;
      remaining <= '0;
      done <= 1'b0;
    end else begin
      {s1, s2, s3} <= {slowClk, s1, s2};
      state <= state_n;
      pre <= pre_n;
      remaining <= rem_n;
      done <= done_n;
    end
  assign tick = s2 & ~s3;
  assign busy = state != IDLE;
  // load has priority over pause, tick and completion in every state
  always_comb begin
    state_n = state;
    pre_n = pre;
    rem_n = remaining;
    done_n = 1'b0;
    if (load) begin
      pre_n = '0;
      rem_n = duration;
      state_n = duration != '0 ? RUN : IDLE;
      done_n = duration == '0;
    end else if (state == RUN) begin
      if (pause) state_n = PAUSED;
      else if (tick) begin
        pre_n = pre == PRE_MAX ? 8'd0 : pre + 8'd1;
        if (pre == PRE_MAX) begin
          rem_n = remaining - DW'(1);
          state_n = remaining == DW'(1) ? IDLE : RUN;
          done_n = remaining == DW'(1);
        end
      end
    end else if (state == PAUSED && !pause) state_n = RUN;
  end
endmodule

// File: tb/tb_phase_tick_timer.sv
// tb_phase_tick_timer: cycle-accurate directed vectors for phase_tick_timer with TICKS_PER_UNIT=2
module tb_phase_tick_timer;
  logic inClk = 1'b0, reset = 1'b1, slowClk = 1'b1, load = 1'b0, pause = 1'b0;
  logic [7:0] duration = '0, remaining;
  logic tick, busy, done;
  int n_chk = 0, n_fail = 0;

  phase_tick_timer #(.DW(8), .TICKS_PER_UNIT(2)) dut (
    .inClk(inClk), .reset(reset), .slowClk(slowClk), .load(load), .duration(duration),
    .pause(pause), .tick(tick), .busy(busy), .done(done), .remaining(remaining)
  );

  always #5 inClk = ~inClk;

  typedef struct {
    logic rst, slow, ld;
    logic [7:0] dur;
    logic ps, t, b, d;
    logic [7:0] r;
  } vec_t;
  vec_t v[$];

  task automatic a(logic rst, logic slow, logic ld, logic [7:0] dur, logic ps,
                   logic t, logic b, logic d, logic [7:0] r);
    v.push_back('{rst, slow, ld, dur, ps, t, b, d, r});
  endtask

  task automatic chk(string nm, int i, logic [7:0] act, logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at step %0d: got %0h expected %0h", nm, i, act, exp);
    end
  endtask

  initial begin
    // idle: 3 reset cycles, then slowClk toggling every 5 cycles with no load
    for (int c = 0; c < 3; c++) begin
      @(posedge inClk); #1;
      chk("rst_tick", c, 8'(tick), 8'd0);
      chk("rst_busy", c, 8'(busy), 8'd0);
      chk("rst_done", c, 8'(done), 8'd0);
      chk("rst_rem", c, remaining, 8'd0);
    end
    reset = 1'b0;
    for (int c = 0; c < 60; c++) begin
      slowClk = (c / 5) % 2 == 1;
      @(posedge inClk); #1;
      chk("idle_tick", c, 8'(tick), 8'((c % 10) == 6));
      chk("idle_quiet", c, {busy, done, remaining[5:0]}, 8'd0);
      chk("idle_rem", c, remaining, 8'd0);
    end
    // rst slow ld dur ps | tick busy done rem ; slowClk rises every 2 cycles
    a(1,1,0,0,0, 0,0,0,0); a(1,1,0,0,0, 0,0,0,0); a(1,1,0,0,0, 0,0,0,0);
    a(0,0,0,0,0, 0,0,0,0);
    // basic phase: duration 3, 6 ticks to done
    a(0,1,1,3,0, 0,1,0,3); a(0,0,0,0,0, 1,1,0,3); a(0,1,0,0,0, 0,1,0,3); a(0,0,0,0,0, 1,1,0,3);
    a(0,1,0,0,0, 0,1,0,2); a(0,0,0,0,0, 1,1,0,2); a(0,1,0,0,0, 0,1,0,2); a(0,0,0,0,0, 1,1,0,2);
    a(0,1,0,0,0, 0,1,0,1); a(0,0,0,0,0, 1,1,0,1); a(0,1,0,0,0, 0,1,0,1); a(0,0,0,0,0, 1,1,0,1);
    a(0,1,0,0,0, 0,0,1,0); a(0,0,0,0,0, 1,0,0,0);
    // pause across 3 ticks, the first coincident with pause rising
    a(0,1,1,2,0, 0,1,0,2); a(0,0,0,0,0, 1,1,0,2); a(0,1,0,0,0, 0,1,0,2); a(0,0,0,0,0, 1,1,0,2);
    a(0,1,0,0,1, 0,1,0,2); a(0,0,0,0,1, 1,1,0,2); a(0,1,0,0,1, 0,1,0,2); a(0,0,0,0,1, 1,1,0,2);
    a(0,1,0,0,1, 0,1,0,2); a(0,0,0,0,0, 1,1,0,2);
    a(0,1,0,0,0, 0,1,0,1); a(0,0,0,0,0, 1,1,0,1); a(0,1,0,0,0, 0,1,0,1); a(0,0,0,0,0, 1,1,0,1);
    a(0,1,0,0,0, 0,0,1,0); a(0,0,0,0,0, 1,0,0,0);
    // reload with duration 5 on the completing tick
    a(0,1,1,2,0, 0,1,0,2); a(0,0,0,0,0, 1,1,0,2); a(0,1,0,0,0, 0,1,0,2); a(0,0,0,0,0, 1,1,0,2);
    a(0,1,0,0,0, 0,1,0,1); a(0,0,0,0,0, 1,1,0,1); a(0,1,0,0,0, 0,1,0,1); a(0,0,0,0,0, 1,1,0,1);
    a(0,1,1,5,0, 0,1,0,5); a(0,0,0,0,0, 1,1,0,5); a(0,1,0,0,0, 0,1,0,5); a(0,0,0,0,0, 1,1,0,5);
    a(0,1,0,0,0, 0,1,0,4); a(0,0,0,0,0, 1,1,0,4);
    // reset mid-phase, then a normal 1-unit phase
    a(1,1,0,0,0, 0,0,0,0); a(0,0,0,0,0, 0,0,0,0);
    a(0,1,1,1,0, 0,1,0,1); a(0,0,0,0,0, 1,1,0,1); a(0,1,0,0,0, 0,1,0,1); a(0,0,0,0,0, 1,1,0,1);
    a(0,1,0,0,0, 0,0,1,0); a(0,0,0,0,0, 1,0,0,0);
    // zero duration in IDLE
    a(0,1,1,0,0, 0,0,1,0); a(0,0,0,0,0, 1,0,0,0);
    foreach (v[i]) begin
      reset = v[i].rst; slowClk = v[i].slow; load = v[i].ld; duration = v[i].dur; pause = v[i].ps;
      @(posedge inClk); #1;
      chk("tick", i, 8'(tick), 8'(v[i].t));
      chk("busy", i, 8'(busy), 8'(v[i].b));
      chk("done", i, 8'(done), 8'(v[i].d));
      chk("remaining", i, remaining, v[i].r);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
